cursor_ctrl_accel: RTL and testbench

- Parametrised next-generation cursor controller for the vector display.
- Takes raw, unsynchronised direction buttons and a recenter request; internally synchronises and debounces them.
- Produces a saturating X/Y cursor position with hold-to-repeat and step acceleration.
- Replaces the separate per-button debounce instances plus the fixed single-step cursor unit; feeds xcursor/ycursor of top_rtl directly.

---
 rtl/cursor_ctrl_accel.sv | 249 ++++++++++++++++++++++++
 tb/tb_cursor_ctrl_accel.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cursor_ctrl_accel.sv
`default_nettype none
// ============================================================================
// Module   : cursor_ctrl_accel
// Purpose  : X/Y cursor controller driven by raw direction buttons. Each
//            button goes through a 2-FF synchroniser and a debounce counter.
//            Each axis then runs a hold-to-repeat FSM with step acceleration.
//            The resulting positions saturate at MINVAL/MAXVAL.
// Ports    : clk        - system clock
//            rst_n      - synchronous active-low reset
//            btnU/D/L/R - raw asynchronous direction buttons
//            recenter   - one-cycle pulse, both coordinates go to centre
//            xcursor    - X position (OUTWIDTH bits)
//            ycursor    - Y position (OUTWIDTH bits)
//            moved      - one-cycle pulse after either coordinate changed
// Revision : 1.0 - initial release
// ============================================================================
module cursor_ctrl_accel #(
  parameter int OUTWIDTH      = 8,
  parameter int MINVAL        = 10,
  parameter int MAXVAL        = 245,
  parameter int STEP          = 5,
  parameter int STEP_FAST     = 20,
  parameter int DB_CYCLES     = 800000,
  parameter int REPEAT_DELAY  = 40000000,
  parameter int REPEAT_PERIOD = 8000000,
  parameter int ACCEL_COUNT   = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                btnU,
  input  logic                btnD,
  input  logic                btnL,
  input  logic                btnR,
  input  logic                recenter,
  output logic [OUTWIDTH-1:0] xcursor,
  output logic [OUTWIDTH-1:0] ycursor,
  output logic                moved
);

  localparam int C_AW      = OUTWIDTH + 2;
  localparam int C_DBW     = $clog2(DB_CYCLES);
  localparam int C_CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int C_CW      = $clog2(C_CNT_MAX);
  localparam int C_RW      = $clog2(ACCEL_COUNT + 2);

  localparam logic [OUTWIDTH-1:0] C_CENTER = OUTWIDTH'((MINVAL + MAXVAL) / 2);
  localparam logic [OUTWIDTH-1:0] C_MAX    = OUTWIDTH'(MAXVAL);
  localparam logic [OUTWIDTH-1:0] C_MIN    = OUTWIDTH'(MINVAL);

  localparam logic signed [C_AW-1:0] C_MAX_S  = C_AW'(MAXVAL);
  localparam logic signed [C_AW-1:0] C_MIN_S  = C_AW'(MINVAL);
  localparam logic signed [C_AW-1:0] C_STEP_S = C_AW'(STEP);
  localparam logic signed [C_AW-1:0] C_FAST_S = C_AW'(STEP_FAST);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HOLD   = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  // Button bit order: 0=R, 1=L, 2=D, 3=U
  logic [3:0] w_raw;
  logic [3:0] r_sync1;
  logic [3:0] r_sync2;
  logic [3:0] w_db;
  logic [1:0] w_plus;
  logic [1:0] w_minus;
  logic [1:0] w_changed;
  logic [1:0][OUTWIDTH-1:0] w_pos;
  logic       r_moved;

  assign w_raw = {btnU, btnD, btnL, btnR};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: the level flips only after DB_CYCLES consecutive samples
  // that disagree with it; any agreeing sample restarts the count.
  for (genvar b = 0; b < 4; b++) begin : g_btn
    logic [C_DBW-1:0] r_cnt;
    logic             r_db;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_cnt <= '0;
        r_db  <= 1'b0;
      end else if (r_sync2[b] == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == C_DBW'(DB_CYCLES - 1)) begin
        r_cnt <= '0;
        r_db  <= ~r_db;
      end else begin
        r_cnt <= r_cnt + C_DBW'(1);
      end
    end

    assign w_db[b] = r_db;
  end

  assign w_plus  = {w_db[3], w_db[0]};
  assign w_minus = {w_db[2], w_db[1]};

  // Axis 0 = X (R/L), axis 1 = Y (U/D)
  for (genvar a = 0; a < 2; a++) begin : g_axis
    state_t                   r_state;
    state_t                   w_state_next;
    logic [C_CW-1:0]          r_cnt;
    logic [C_CW-1:0]          w_cnt_next;
    logic [C_RW-1:0]          r_rep;
    logic [C_RW-1:0]          w_rep_next;
    logic [1:0]               r_dir;
    logic [1:0]               w_dir_next;
    logic [1:0]               w_dir;
    logic                     w_step;
    logic                     w_fast;
    logic signed [C_AW-1:0]   w_pos_s;
    logic signed [C_AW-1:0]   w_size;
    logic signed [C_AW-1:0]   w_sum;
    logic signed [C_AW-1:0]   w_diff;
    logic [OUTWIDTH-1:0]      w_stepped;
    logic [OUTWIDTH-1:0]      w_pos_next;
    logic [OUTWIDTH-1:0]      r_pos;

    // One-hot direction: bit0 = plus, bit1 = minus, 00 = none or conflict
    assign w_dir = {w_minus[a] & ~w_plus[a], w_plus[a] & ~w_minus[a]};

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_rep   <= '0;
        r_dir   <= 2'b00;
      end else begin
        r_state <= w_state_next;
        r_cnt   <= w_cnt_next;
        r_rep   <= w_rep_next;
        r_dir   <= w_dir_next;
      end
    end

    always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_rep_next   = r_rep;
      w_dir_next   = r_dir;
      w_step       = 1'b0;
      w_fast       = 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_dir != 2'b00) begin
            w_step       = 1'b1;
            w_dir_next   = w_dir;
            w_cnt_next   = '0;
            w_state_next = S_HOLD;
          end
        end
        S_HOLD: begin
          if (w_dir != r_dir) begin
            w_state_next = S_IDLE;
          end else if (r_cnt == C_CW'(REPEAT_DELAY - 1)) begin
            w_step       = 1'b1;
            w_rep_next   = C_RW'(1);
            w_cnt_next   = '0;
            w_state_next = S_REPEAT;
          end else begin
            w_cnt_next = r_cnt + C_CW'(1);
          end
        end
        S_REPEAT: begin
          if (w_dir != r_dir) begin
            w_state_next = S_IDLE;
          end else if (r_cnt == C_CW'(REPEAT_PERIOD - 1)) begin
            // The first repeat is the HOLD step, so this one is repeat
            // number rep+1; only the first ACCEL_COUNT repeats use STEP.
            w_step     = 1'b1;
            w_fast     = (r_rep >= C_RW'(ACCEL_COUNT));
            w_cnt_next = '0;
            if (r_rep < C_RW'(ACCEL_COUNT + 1)) begin
              w_rep_next = r_rep + C_RW'(1);
            end
          end else begin
            w_cnt_next = r_cnt + C_CW'(1);
          end
        end
        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end

    // Widened signed arithmetic so the sum/difference cannot wrap
    // before being clamped.
    assign w_pos_s = $signed({2'b00, r_pos});
    assign w_size  = w_fast ? C_FAST_S : C_STEP_S;
    assign w_sum   = w_pos_s + w_size;
    assign w_diff  = w_pos_s - w_size;

    always_comb begin
      w_stepped = r_pos;
      if (w_dir[0]) begin
        w_stepped = (w_sum > C_MAX_S) ? C_MAX : w_sum[OUTWIDTH-1:0];
      end else begin
        w_stepped = (w_diff < C_MIN_S) ? C_MIN : w_diff[OUTWIDTH-1:0];
      end
    end

    // Recenter overrides any step taken on the same edge
    always_comb begin
      w_pos_next = r_pos;
      if (recenter) begin
        w_pos_next = C_CENTER;
      end else if (w_step) begin
        w_pos_next = w_stepped;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_pos <= C_CENTER;
      end else begin
        r_pos <= w_pos_next;
      end
    end

    assign w_changed[a] = (w_pos_next != r_pos);
    assign w_pos[a]     = r_pos;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_moved <= 1'b0;
    end else begin
      r_moved <= |w_changed;
    end
  end

  assign xcursor = w_pos[0];
  assign ycursor = w_pos[1];
  assign moved   = r_moved;

endmodule
`default_nettype wire

// File: tb/tb_cursor_ctrl_accel.sv
`default_nettype none
// ============================================================================
// Module   : tb_cursor_ctrl_accel
// Purpose  : Self-checking bench for cursor_ctrl_accel. A behavioural model
//            predicts every cursor move and queues it; a monitor pops the
//            queue on each moved pulse and compares cycle and position.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cursor_ctrl_accel;

  localparam int OW     = 8;
  localparam int MINV   = 10;
  localparam int MAXV   = 245;
  localparam int STP    = 5;
  localparam int STPF   = 20;
  localparam int DB     = 4;
  localparam int RD     = 10;
  localparam int RP     = 4;
  localparam int AC     = 3;
  localparam int CENTER = (MINV + MAXV) / 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          btnU = 1'b0;
  logic          btnD = 1'b0;
  logic          btnL = 1'b0;
  logic          btnR = 1'b0;
  logic          recenter = 1'b0;
  logic [OW-1:0] xcursor;
  logic [OW-1:0] ycursor;
  logic          moved;

  cursor_ctrl_accel #(
    .OUTWIDTH(OW), .MINVAL(MINV), .MAXVAL(MAXV), .STEP(STP), .STEP_FAST(STPF),
    .DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .ACCEL_COUNT(AC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .btnU(btnU), .btnD(btnD), .btnL(btnL), .btnR(btnR),
    .recenter(recenter),
    .xcursor(xcursor), .ycursor(ycursor), .moved(moved)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int x;
    int y;
  } exp_t;

  exp_t q[$];
  int   nvec = 0;
  int   nerr = 0;

  // ---------------- behavioural reference model ----------------
  int       cyc = 0;
  bit       rst_edge = 1'b1;
  int       m_x = CENTER;
  int       m_y = CENTER;
  bit [3:0] m_s1, m_s2, m_db;
  bit [3:0] m_hist[$];
  bit       m_act[2];
  int       m_ldir[2];
  int       m_t[2];
  int       md[2];
  int       msz[2];
  int       mk, mnx, mny;
  bit       mall;

  function automatic int dir_of(input bit p, input bit n);
    if (p && !n) return 1;
    if (n && !p) return -1;
    return 0;
  endfunction

  function automatic int clampi(input int v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  always @(posedge clk) begin
    cyc++;
    rst_edge = !rst_n;
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_db = '0;
      m_hist.delete();
      m_act[0] = 1'b0; m_act[1] = 1'b0;
      m_x = CENTER; m_y = CENTER;
    end else begin
      md[0] = dir_of(m_db[0], m_db[1]);
      md[1] = dir_of(m_db[3], m_db[2]);
      for (int a = 0; a < 2; a++) begin
        msz[a] = 0;
        if (!m_act[a]) begin
          if (md[a] != 0) begin
            msz[a] = STP; m_act[a] = 1'b1; m_ldir[a] = md[a]; m_t[a] = 0;
          end
        end else if (md[a] != m_ldir[a]) begin
          m_act[a] = 1'b0;
        end else begin
          // t = cycles held since the first step; repeats at RD, RD+RP, ...
          m_t[a]++;
          if (m_t[a] >= RD && ((m_t[a] - RD) % RP) == 0) begin
            mk = 1 + (m_t[a] - RD) / RP;
            msz[a] = (mk <= AC) ? STP : STPF;
          end
        end
      end
      mnx = clampi(m_x + md[0] * msz[0]);
      mny = clampi(m_y + md[1] * msz[1]);
      if (recenter) begin
        mnx = CENTER; mny = CENTER;
      end
      if (mnx != m_x || mny != m_y) q.push_back('{cyc: cyc, x: mnx, y: mny});
      m_x = mnx; m_y = mny;
      // Debounced level flips when the last DB synchronised samples all
      // disagree with it.
      m_hist.push_back(m_s2);
      if (m_hist.size() > DB) void'(m_hist.pop_front());
      if (m_hist.size() == DB) begin
        for (int b = 0; b < 4; b++) begin
          mall = 1'b1;
          foreach (m_hist[i]) if (m_hist[i][b] == m_db[b]) mall = 1'b0;
          if (mall) m_db[b] = ~m_db[b];
        end
      end
      m_s2 = m_s1;
      m_s1 = {btnU, btnD, btnL, btnR};
    end
  end

  // ---------------- monitor / scoreboard ----------------
  exp_t    e;
  int      px, py;
  bit      have_prev = 1'b0;

  always @(negedge clk) begin
    if (moved) begin
      nvec++;
      if (q.size() == 0) begin
        nerr++;
        $display("FAIL unexpected_move cyc=%0d got x=%0d y=%0d, no move expected", cyc, xcursor, ycursor);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || e.x != int'(xcursor) || e.y != int'(ycursor)) begin
          nerr++;
          $display("FAIL move cyc=%0d got x=%0d y=%0d, expected x=%0d y=%0d at cyc=%0d",
                   cyc, xcursor, ycursor, e.x, e.y, e.cyc);
        end
      end
    end
    if (q.size() > 0 && q[0].cyc <= cyc) begin
      nvec++;
      nerr++;
      $display("FAIL missed_move cyc=%0d got moved=%0d x=%0d y=%0d, expected x=%0d y=%0d",
               cyc, moved, xcursor, ycursor, q[0].x, q[0].y);
      void'(q.pop_front());
    end
    if (have_prev && !rst_edge && !moved && (int'(xcursor) != px || int'(ycursor) != py)) begin
      nvec++;
      nerr++;
      $display("FAIL stray_change cyc=%0d got x=%0d y=%0d without moved, expected x=%0d y=%0d",
               cyc, xcursor, ycursor, px, py);
    end
    px = int'(xcursor);
    py = int'(ycursor);
    have_prev = 1'b1;
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkpoint(input string name);
    check_val({name, "_x"}, int'(xcursor), m_x);
    check_val({name, "_y"}, int'(ycursor), m_y);
    check_val({name, "_pending"}, q.size(), 0);
  endtask

  task automatic set_btn(input bit u, input bit d, input bit l, input bit r);
    btnU = u; btnD = d; btnL = l; btnR = r;
  endtask

  int n;
  int sel;
  int len;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    // Reset with buttons toggling
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_btn(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      tick(1);
      check_val("reset_x", int'(xcursor), CENTER);
      check_val("reset_moved", int'(moved), 0);
    end
    set_btn(0, 0, 0, 0);
    rst_n = 1'b1;
    tick(15);
    check_val("post_reset_x", int'(xcursor), 127);
    check_val("post_reset_y", int'(ycursor), 127);

    // Single tap right
    set_btn(0, 0, 0, 1);
    tick(8);
    set_btn(0, 0, 0, 0);
    tick(25);
    check_val("tap_right_x", int'(xcursor), 132);
    checkpoint("tap");

    // Hold up through repeat and acceleration to the upper limit
    set_btn(1, 0, 0, 0);
    tick(70);
    set_btn(0, 0, 0, 0);
    tick(25);
    check_val("hold_up_y", int'(ycursor), 245);
    checkpoint("hold_up");

    // Conflict L+R, then release R
    set_btn(0, 0, 1, 1);
    tick(30);
    check_val("conflict_x", int'(xcursor), 132);
    set_btn(0, 0, 1, 0);
    tick(8);
    set_btn(0, 0, 0, 0);
    tick(25);
    check_val("left_after_conflict_x", int'(xcursor), 127);
    // Short glitch on D
    set_btn(0, 1, 0, 0);
    tick(2);
    set_btn(0, 0, 0, 0);
    tick(25);
    check_val("glitch_y", int'(ycursor), 245);
    checkpoint("glitch");

    // Recenter, then recenter again during a fast down-repeat
    recenter = 1'b1;
    tick(1);
    recenter = 1'b0;
    tick(20);
    check_val("recenter_y", int'(ycursor), 127);
    set_btn(0, 1, 0, 0);
    n = 0;
    while (int'(ycursor) != 87 && n < 100) begin
      tick(1);
      n++;
    end
    check_val("reach_87", int'(ycursor), 87);
    recenter = 1'b1;
    tick(1);
    recenter = 1'b0;
    check_val("mid_recenter_y", int'(ycursor), 127);
    check_val("mid_recenter_moved", int'(moved), 1);
    tick(1);
    n = 0;
    while (!moved && n < 20) begin
      tick(1);
      n++;
    end
    check_val("fast_after_recenter_y", int'(ycursor), 107);
    // Reset while D is still held
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    check_val("mid_reset_y", int'(ycursor), 127);
    tick(4);
    check_val("held_after_reset_y", int'(ycursor), 127);
    tick(6);
    set_btn(0, 0, 0, 0);
    tick(25);
    check_val("debounce_again_y", int'(ycursor), 122);
    checkpoint("mid_op");

    // Drive X to the lower limit, then tap left
    set_btn(0, 0, 1, 0);
    n = 0;
    while (int'(xcursor) != 10 && n < 150) begin
      tick(1);
      n++;
    end
    set_btn(0, 0, 0, 0);
    tick(25);
    check_val("low_limit_x", int'(xcursor), 10);
    set_btn(0, 0, 1, 0);
    tick(8);
    set_btn(0, 0, 0, 0);
    tick(25);
    check_val("low_tap_x", int'(xcursor), 10);
    checkpoint("sat_low");

    // Randomised phase
    for (int i = 0; i < 150; i++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0: set_btn(0, 0, 0, 0);
        1: set_btn(1, 0, 0, 0);
        2: set_btn(0, 1, 0, 0);
        3: set_btn(0, 0, 1, 0);
        4: set_btn(0, 0, 0, 1);
        default: set_btn(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      endcase
      len = $urandom_range(1, 40);
      for (int j = 0; j < len; j++) begin
        recenter = ($urandom_range(0, 39) == 0);
        rst_n = ($urandom_range(0, 299) != 0);
        tick(1);
      end
    end
    recenter = 1'b0;
    rst_n = 1'b1;
    set_btn(0, 0, 0, 0);
    tick(40);
    checkpoint("random_end");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
